// File: rtl/rf_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_sequencer_if                                                      |
// | Instruction, register-file, ALU and status bundle of rf_sequencer.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface rf_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_op;
   logic [3:0]       in_rd;
   logic [3:0]       in_rs1;
   logic [3:0]       in_rs2;
   logic [31:0]      in_imm;
   logic             rf_en;
   logic             rf_rd;
   logic             rf_wr;
   logic             rf_rst;
   logic [3:0]       rf_sel_i1;
   logic [3:0]       rf_sel_o1;
   logic [3:0]       rf_sel_o2;
   logic [31:0]      rf_wdata;
   logic [31:0]      rf_op_1;
   logic [31:0]      rf_op_2;
   logic [31:0]      alu_a;
   logic [31:0]      alu_b;
   logic [2:0]       alu_op;
   logic [31:0]      alu_result;
   logic             done;
   logic [3:0]       done_rd;
   logic             err;
   logic [CNT_W-1:0] instr_cnt;

   // Environment side: issues instructions, hosts the register file and ALU.
   modport master (
      output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
      output rf_op_1, rf_op_2, alu_result,
      input  in_ready, rf_en, rf_rd, rf_wr, rf_rst, rf_sel_i1, rf_sel_o1, rf_sel_o2,
      input  rf_wdata, alu_a, alu_b, alu_op, done, done_rd, err, instr_cnt
   );

   modport slave (
      input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
      input  rf_op_1, rf_op_2, alu_result,
      output in_ready, rf_en, rf_rd, rf_wr, rf_rst, rf_sel_i1, rf_sel_o1, rf_sel_o2,
      output rf_wdata, alu_a, alu_b, alu_op, done, done_rd, err, instr_cnt
   );
endinterface
`default_nettype wire

// File: rtl/rf_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_sequencer                                                         |
// | Multi-cycle sequencer driving a register file and external ALU.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rf_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic          clk,
   input  logic          rst,
   rf_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_EXEC  = 3'd2,
      ST_WRITE = 3'd3,
      ST_CLEAR = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [3:0] c_OP_LDI = 4'b1000;
   localparam logic [3:0] c_OP_MOV = 4'b1001;
   localparam logic [3:0] c_OP_CLR = 4'b1100;
   localparam logic [3:0] c_OP_NOP = 4'b1110;

   state_t           r_state;
   logic [3:0]       r_op;
   logic [3:0]       r_rd;
   logic             r_rf_en;
   logic             r_rf_rd;
   logic             r_rf_wr;
   logic             r_rf_rst;
   logic [3:0]       r_sel_i1;
   logic [3:0]       r_sel_o1;
   logic [3:0]       r_sel_o2;
   logic [31:0]      r_wdata;
   logic             r_done;
   logic [3:0]       r_done_rd;
   logic             r_err;
   logic [CNT_W-1:0] r_instr_cnt;
   logic             w_alu_exec;

   // ALU operands are a pass-through of the read data, so they cannot be registered.
   assign w_alu_exec    = (r_state == ST_EXEC) && !r_op[3];
   assign bus.alu_a     = w_alu_exec ? bus.rf_op_1 : 32'd0;
   assign bus.alu_b     = w_alu_exec ? bus.rf_op_2 : 32'd0;
   assign bus.alu_op    = w_alu_exec ? r_op[2:0]   : 3'd0;

   assign bus.in_ready  = (r_state == ST_IDLE);
   assign bus.rf_en     = r_rf_en;
   assign bus.rf_rd     = r_rf_rd;
   assign bus.rf_wr     = r_rf_wr;
   assign bus.rf_rst    = r_rf_rst;
   assign bus.rf_sel_i1 = r_sel_i1;
   assign bus.rf_sel_o1 = r_sel_o1;
   assign bus.rf_sel_o2 = r_sel_o2;
   assign bus.rf_wdata  = r_wdata;
   assign bus.done      = r_done;
   assign bus.done_rd   = r_done_rd;
   assign bus.err       = r_err;
   assign bus.instr_cnt = r_instr_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_op        <= 4'd0;
         r_rd        <= 4'd0;
         r_rf_en     <= 1'b0;
         r_rf_rd     <= 1'b0;
         r_rf_wr     <= 1'b0;
         r_rf_rst    <= 1'b0;
         r_sel_i1    <= 4'd0;
         r_sel_o1    <= 4'd0;
         r_sel_o2    <= 4'd0;
         r_wdata     <= 32'd0;
         r_done      <= 1'b0;
         r_done_rd   <= 4'd0;
         r_err       <= 1'b0;
         r_instr_cnt <= '0;
      end else begin
         // Outputs are set on the edge entering the state that owns them.
         r_rf_en   <= 1'b0;
         r_rf_rd   <= 1'b0;
         r_rf_wr   <= 1'b0;
         r_rf_rst  <= 1'b0;
         r_sel_i1  <= 4'd0;
         r_sel_o1  <= 4'd0;
         r_sel_o2  <= 4'd0;
         r_wdata   <= 32'd0;
         r_done    <= 1'b0;
         r_done_rd <= 4'd0;
         r_err     <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  r_op <= bus.in_op;
                  r_rd <= bus.in_rd;
                  if (!bus.in_op[3] || bus.in_op == c_OP_MOV) begin
                     r_state  <= ST_READ;
                     r_rf_en  <= 1'b1;
                     r_rf_rd  <= 1'b1;
                     r_sel_o1 <= bus.in_rs1;
                     r_sel_o2 <= bus.in_rs2;
                  end else if (bus.in_op == c_OP_LDI) begin
                     r_state  <= ST_WRITE;
                     r_rf_en  <= 1'b1;
                     r_rf_wr  <= 1'b1;
                     r_sel_i1 <= bus.in_rd;
                     r_wdata  <= bus.in_imm;
                  end else if (bus.in_op == c_OP_CLR) begin
                     r_state  <= ST_CLEAR;
                     r_rf_en  <= 1'b1;
                     r_rf_rst <= 1'b1;
                  end else if (bus.in_op == c_OP_NOP) begin
                     r_state     <= ST_DONE;
                     r_done      <= 1'b1;
                     r_instr_cnt <= r_instr_cnt + 1'b1;
                  end else begin
                     r_state <= ST_DONE;
                     r_err   <= 1'b1;
                  end
               end
            end
            ST_READ: r_state <= ST_EXEC;
            ST_EXEC: begin
               r_state  <= ST_WRITE;
               r_rf_en  <= 1'b1;
               r_rf_wr  <= 1'b1;
               r_sel_i1 <= r_rd;
               r_wdata  <= r_op[3] ? bus.rf_op_1 : bus.alu_result;
            end
            ST_WRITE: begin
               r_state     <= ST_DONE;
               r_done      <= 1'b1;
               r_done_rd   <= r_rd;
               r_instr_cnt <= r_instr_cnt + 1'b1;
            end
            ST_CLEAR: begin
               r_state     <= ST_DONE;
               r_done      <= 1'b1;
               r_instr_cnt <= r_instr_cnt + 1'b1;
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_rf_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rf_sequencer                                                      |
// | Directed bench with a timeline model of rf_sequencer outputs.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rf_sequencer;
   localparam int CNT_W = 4;
   localparam int DEPTH = 4096;

   typedef struct packed {
      logic        en, rd, wr, rs;
      logic [3:0]  i1, o1, o2;
      logic [31:0] wd, a, b;
      logic [2:0]  aop;
      logic        done;
      logic [3:0]  drd;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rf_sequencer_if #(.CNT_W(CNT_W)) bus();
   rf_sequencer #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return a << b[4:0];
         3'd6:    return a >> b[4:0];
         default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      endcase
   endfunction

   // Environment: external ALU and a register file that answers the DUT strobes.
   assign bus.alu_result = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
   logic [31:0] env_regs [16] = '{default: 32'd0};
   always @(posedge clk) begin
      if (bus.rf_en === 1'b1 && bus.rf_rd === 1'b1) begin
         bus.rf_op_1 <= env_regs[bus.rf_sel_o1];
         bus.rf_op_2 <= env_regs[bus.rf_sel_o2];
      end
      if (bus.rf_en === 1'b1 && bus.rf_wr === 1'b1) env_regs[bus.rf_sel_i1] <= bus.rf_wdata;
      if (bus.rf_en === 1'b1 && bus.rf_rst === 1'b1)
         for (int i = 0; i < 16; i++) env_regs[i] <= 32'd0;
   end

   // Model: expected outputs per cycle, architectural register contents, busy window.
   exp_t        ex [DEPTH];
   logic [31:0] mregs [16] = '{default: 32'd0};
   logic [31:0] mregs_prev [16];
   int          busy_until = 0;
   int          rst_epoch = 0;
   int          seen_epoch = 0;
   int          mcnt = 0;
   bit          chk_en = 1'b0;
   exp_t        exp_s, act_s;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (seen_epoch != rst_epoch) begin
            mcnt = 0;
            seen_epoch = rst_epoch;
         end
         exp_s = ex[cyc];
         if (exp_s.done) mcnt++;
         act_s = {bus.rf_en, bus.rf_rd, bus.rf_wr, bus.rf_rst, bus.rf_sel_i1, bus.rf_sel_o1,
                  bus.rf_sel_o2, bus.rf_wdata, bus.alu_a, bus.alu_b, bus.alu_op, bus.done,
                  bus.done_rd, bus.err};
         chk("outputs", act_s, exp_s);
         chk("in_ready", bus.in_ready, (cyc >= busy_until) ? 1'b1 : 1'b0);
         chk("instr_cnt", bus.instr_cnt, mcnt % (1 << CNT_W));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Place the expected effects of an instruction accepted at the edge giving cycle t.
   task automatic schedule(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                           input logic [3:0] rs2, input logic [31:0] imm, input int t);
      logic [31:0] va, vb, res;
      mregs_prev = mregs;
      if (!op[3] || op == 4'b1001) begin
         va  = mregs[rs1];
         vb  = mregs[rs2];
         res = op[3] ? va : alu_f(op[2:0], va, vb);
         ex[t].en = 1'b1; ex[t].rd = 1'b1; ex[t].o1 = rs1; ex[t].o2 = rs2;
         if (!op[3]) begin
            ex[t+1].a = va; ex[t+1].b = vb; ex[t+1].aop = op[2:0];
         end
         ex[t+2].en = 1'b1; ex[t+2].wr = 1'b1; ex[t+2].i1 = rd; ex[t+2].wd = res;
         ex[t+3].done = 1'b1; ex[t+3].drd = rd;
         mregs[rd] = res;
         busy_until = t + 4;
      end else if (op == 4'b1000) begin
         ex[t].en = 1'b1; ex[t].wr = 1'b1; ex[t].i1 = rd; ex[t].wd = imm;
         ex[t+1].done = 1'b1; ex[t+1].drd = rd;
         mregs[rd] = imm;
         busy_until = t + 2;
      end else if (op == 4'b1100) begin
         ex[t].en = 1'b1; ex[t].rs = 1'b1;
         ex[t+1].done = 1'b1;
         for (int i = 0; i < 16; i++) mregs[i] = 32'd0;
         busy_until = t + 2;
      end else if (op == 4'b1110) begin
         ex[t].done = 1'b1;
         busy_until = t + 1;
      end else begin
         ex[t].err = 1'b1;
         busy_until = t + 1;
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [31:0] imm);
      int n = 0;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) chk("ready_timeout", bus.in_ready, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_op = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
      step();
      // Junk on the inputs while not valid must be ignored.
      bus.in_valid = 1'b0;
      bus.in_op = 4'b1100; bus.in_rd = 4'hF; bus.in_rs1 = 4'hE; bus.in_rs2 = 4'hD;
      bus.in_imm = $urandom;
      schedule(op, rd, rs1, rs2, imm, cyc);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = cyc; i < cyc + 16; i++) ex[i] = '0;
      busy_until = cyc;
      rst_epoch++;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) ex[i] = '0;
      bus.in_valid = 1'b0;
      bus.in_op = 4'd0; bus.in_rd = 4'd0; bus.in_rs1 = 4'd0; bus.in_rs2 = 4'd0; bus.in_imm = 32'd0;
      step();
      chk_en = 1'b1;
      step();
      rst = 1'b0;
      chk("reset_cnt", bus.instr_cnt, 4'd0);
      chk("reset_ready", bus.in_ready, 1'b1);
      chk("reset_strobes", {bus.rf_en, bus.rf_wr, bus.done, bus.err}, 4'b0000);

      issue(4'b1000, 4'd3, 4'd0, 4'd0, 32'h0000_00A5);
      chk("ldi_write", {bus.rf_wr, bus.rf_sel_i1, bus.rf_wdata}, {1'b1, 4'd3, 32'h0000_00A5});
      step();
      chk("ldi_done", {bus.done, bus.done_rd}, {1'b1, 4'd3});
      issue(4'b1110, 4'd7, 4'd0, 4'd0, 32'd0);
      chk("nop_done", {bus.done, bus.done_rd, bus.instr_cnt}, {1'b1, 4'd0, 4'd2});

      issue(4'b1000, 4'd3, 4'd0, 4'd0, 32'd7);
      issue(4'b1000, 4'd4, 4'd0, 4'd0, 32'd9);
      issue(4'b0000, 4'd5, 4'd3, 4'd4, 32'd0);
      chk("add_read", {bus.rf_en, bus.rf_rd, bus.rf_sel_o1, bus.rf_sel_o2}, {2'b11, 4'd3, 4'd4});
      step();
      chk("add_alu", {bus.alu_a, bus.alu_b}, {32'd7, 32'd9});
      step();
      chk("add_write", {bus.rf_wr, bus.rf_sel_i1, bus.rf_wdata}, {1'b1, 4'd5, 32'd16});
      step();
      chk("add_done", {bus.done, bus.done_rd}, {1'b1, 4'd5});

      issue(4'b1000, 4'd2, 4'd0, 4'd0, 32'hDEAD_BEEF);
      issue(4'b1001, 4'd2, 4'd2, 4'd0, 32'd0);
      step();
      chk("mov_alu_idle", {bus.alu_a, bus.alu_b, bus.alu_op}, 67'd0);
      step();
      chk("mov_write", {bus.rf_wr, bus.rf_sel_i1, bus.rf_wdata}, {1'b1, 4'd2, 32'hDEAD_BEEF});

      issue(4'b1111, 4'd1, 4'd1, 4'd1, 32'd0);
      chk("ill_err", {bus.err, bus.rf_en, bus.done}, 3'b100);
      step();
      chk("ill_ready", {bus.in_ready, bus.instr_cnt}, {1'b1, 4'd7});

      issue(4'b1100, 4'd9, 4'd0, 4'd0, 32'd0);
      chk("clr_strobe", {bus.rf_en, bus.rf_rst, bus.rf_wr}, 3'b110);
      step();
      chk("clr_done", {bus.done, bus.done_rd}, {1'b1, 4'd0});
      issue(4'b1001, 4'd1, 4'd3, 4'd0, 32'd0);

      issue(4'b1000, 4'd6, 4'd0, 4'd0, 32'h1234_5678);
      issue(4'b1000, 4'd7, 4'd0, 4'd0, 32'hF0F0_0003);
      issue(4'b1000, 4'd8, 4'd0, 4'd0, 32'hFFFF_FFFB);
      for (int op = 0; op < 8; op++)
         issue(op[3:0], (op == 4) ? 4'd6 : (op == 5) ? 4'd8 : 4'(9 + op), 4'd6,
               op[0] ? 4'd8 : 4'd7, 32'd0);
      issue(4'b1010, 4'd2, 4'd2, 4'd2, 32'd0);

      issue(4'b0000, 4'd11, 4'd6, 4'd7, 32'd0);
      step();
      apply_reset();
      mregs = mregs_prev;
      chk("abort_cnt", {bus.instr_cnt, bus.in_ready}, {4'd0, 1'b1});
      repeat (5) step();

      for (int i = 0; i < 15; i++) issue(4'b1110, 4'd0, 4'd0, 4'd0, 32'd0);
      chk("cnt_full", bus.instr_cnt, 4'hF);
      issue(4'b1110, 4'd0, 4'd0, 4'd0, 32'd0);
      chk("cnt_wrap", bus.instr_cnt, 4'h0);
      issue(4'b1001, 4'd12, 4'd6, 4'd0, 32'd0);
      repeat (6) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
